// File: rtl/rs_age_issue.sv
`default_nettype none
// ============================================================================
// Module   : rs_age_issue
// Purpose  : ALU reservation station with CDB wakeup and age-matrix oldest-ready
//            issue. Optional macro RS_WAKEUP_BYPASS_EN lets a CDB broadcast
//            reach the output in the same cycle that it wakes an entry.
// Revision : 1.0
// ============================================================================
module rs_age_issue #(
    parameter int RS_DEPTH   = 16,
    parameter int TAG_W      = 4,
    parameter int DATA_W     = 32,
    parameter int NUM_CDB    = 2,
    parameter int FULL_SLACK = 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          clear,
    input  logic                          dispatch_valid,
    input  logic [DATA_W-1:0]             dispatch_inst,
    input  logic [DATA_W-1:0]             dispatch_pc,
    input  logic [DATA_W-1:0]             dispatch_imm,
    input  logic [TAG_W-1:0]              dispatch_tag,
    input  logic [DATA_W-1:0]             rs1_val,
    input  logic [DATA_W-1:0]             rs2_val,
    input  logic [TAG_W-1:0]              rs1_rely,
    input  logic [TAG_W-1:0]              rs2_rely,
    input  logic                          rob_rs1_hit,
    input  logic                          rob_rs2_hit,
    input  logic [DATA_W-1:0]             rob_rs1_val,
    input  logic [DATA_W-1:0]             rob_rs2_val,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]     cdb_val,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_inst,
    output logic [DATA_W-1:0]             out_pc,
    output logic [DATA_W-1:0]             out_imm,
    output logic [DATA_W-1:0]             out_rs1_val,
    output logic [DATA_W-1:0]             out_rs2_val,
    output logic [TAG_W-1:0]              out_tag,
    output logic                          full_o,
    output logic [$clog2(RS_DEPTH+1)-1:0] count_o,
    output logic                          err_overflow_o
);

    localparam int CNT_W = $clog2(RS_DEPTH + 1);
    localparam int IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0] r_busy;
    logic [DATA_W-1:0]   r_inst  [RS_DEPTH];
    logic [DATA_W-1:0]   r_pc    [RS_DEPTH];
    logic [DATA_W-1:0]   r_imm   [RS_DEPTH];
    logic [TAG_W-1:0]    r_tag   [RS_DEPTH];
    logic [TAG_W-1:0]    r_rely1 [RS_DEPTH];
    logic [TAG_W-1:0]    r_rely2 [RS_DEPTH];
    logic [DATA_W-1:0]   r_val1  [RS_DEPTH];
    logic [DATA_W-1:0]   r_val2  [RS_DEPTH];
    // r_age[i][j] set means entry i was inserted before entry j
    logic [RS_DEPTH-1:0] r_age   [RS_DEPTH];

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_inst, r_out_pc, r_out_imm, r_out_v1, r_out_v2;
    logic [TAG_W-1:0]    r_out_tag;
    logic [CNT_W-1:0]    r_count;
    logic                r_full;
    logic                r_err;

    logic [RS_DEPTH-1:0] w_hit1, w_hit2, w_ready, w_sel;
    logic [DATA_W-1:0]   w_cval1 [RS_DEPTH];
    logic [DATA_W-1:0]   w_cval2 [RS_DEPTH];
    logic [DATA_W-1:0]   w_op1   [RS_DEPTH];
    logic [DATA_W-1:0]   w_op2   [RS_DEPTH];
    logic                w_dhit1, w_dhit2;
    logic [DATA_W-1:0]   w_dcval1, w_dcval2;
    logic [TAG_W-1:0]    w_new_rely1, w_new_rely2;
    logic [DATA_W-1:0]   w_new_val1, w_new_val2;
    logic [IDX_W-1:0]    w_sel_idx, w_free_idx;
    logic                w_any_sel, w_has_free, w_load, w_issue, w_accept;
    logic [CNT_W-1:0]    w_count_nxt;

    // CDB match per pending operand; ports scanned high to low so port 0 wins
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_hit1[i]  = 1'b0;
            w_hit2[i]  = 1'b0;
            w_cval1[i] = '0;
            w_cval2[i] = '0;
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (cdb_valid[k] && r_rely1[i] != '0 && cdb_tag[k*TAG_W +: TAG_W] == r_rely1[i]) begin
                    w_hit1[i]  = 1'b1;
                    w_cval1[i] = cdb_val[k*DATA_W +: DATA_W];
                end
                if (cdb_valid[k] && r_rely2[i] != '0 && cdb_tag[k*TAG_W +: TAG_W] == r_rely2[i]) begin
                    w_hit2[i]  = 1'b1;
                    w_cval2[i] = cdb_val[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        w_dhit1  = 1'b0;
        w_dhit2  = 1'b0;
        w_dcval1 = '0;
        w_dcval2 = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == rs1_rely) begin
                w_dhit1  = 1'b1;
                w_dcval1 = cdb_val[k*DATA_W +: DATA_W];
            end
            if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == rs2_rely) begin
                w_dhit2  = 1'b1;
                w_dcval2 = cdb_val[k*DATA_W +: DATA_W];
            end
        end
        w_new_rely1 = rs1_rely;
        w_new_val1  = '0;
        if (rs1_rely == '0)   w_new_val1 = rs1_val;
        else if (rob_rs1_hit) begin w_new_rely1 = '0; w_new_val1 = rob_rs1_val; end
        else if (w_dhit1)     begin w_new_rely1 = '0; w_new_val1 = w_dcval1;    end
        w_new_rely2 = rs2_rely;
        w_new_val2  = '0;
        if (rs2_rely == '0)   w_new_val2 = rs2_val;
        else if (rob_rs2_hit) begin w_new_rely2 = '0; w_new_val2 = rob_rs2_val; end
        else if (w_dhit2)     begin w_new_rely2 = '0; w_new_val2 = w_dcval2;    end
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
            w_ready[i] = r_busy[i] && (r_rely1[i] == '0 || w_hit1[i]) && (r_rely2[i] == '0 || w_hit2[i]);
`else
            w_ready[i] = r_busy[i] && (r_rely1[i] == '0) && (r_rely2[i] == '0);
`endif
            w_op1[i] = (r_rely1[i] == '0) ? r_val1[i] : w_cval1[i];
            w_op2[i] = (r_rely2[i] == '0) ? r_val2[i] : w_cval2[i];
        end
        w_sel = w_ready;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (j != i && w_ready[j] && r_age[j][i]) w_sel[i] = 1'b0;
            end
        end
        w_any_sel  = 1'b0;
        w_sel_idx  = '0;
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                w_any_sel = 1'b1;
                w_sel_idx = IDX_W'(i);
            end
            if (!r_busy[i]) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_load      = !r_out_valid || out_ready;
    assign w_issue     = w_load && w_any_sel;
    assign w_accept    = dispatch_valid && w_has_free;
    assign w_count_nxt = r_count + CNT_W'(w_accept) - CNT_W'(w_issue);

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            r_busy      <= '0;
            for (int i = 0; i < RS_DEPTH; i++) r_age[i] <= '0;
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_pc    <= '0;
            r_out_imm   <= '0;
            r_out_v1    <= '0;
            r_out_v2    <= '0;
            r_out_tag   <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_err       <= 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (r_busy[i] && w_hit1[i]) begin
                    r_rely1[i] <= '0;
                    r_val1[i]  <= w_cval1[i];
                end
                if (r_busy[i] && w_hit2[i]) begin
                    r_rely2[i] <= '0;
                    r_val2[i]  <= w_cval2[i];
                end
            end
            if (w_issue) r_busy[w_sel_idx] <= 1'b0;
            if (w_load) begin
                r_out_valid <= w_any_sel;
                if (w_any_sel) begin
                    r_out_inst <= r_inst[w_sel_idx];
                    r_out_pc   <= r_pc[w_sel_idx];
                    r_out_imm  <= r_imm[w_sel_idx];
                    r_out_tag  <= r_tag[w_sel_idx];
                    r_out_v1   <= w_op1[w_sel_idx];
                    r_out_v2   <= w_op2[w_sel_idx];
                end
            end
            if (w_accept) begin
                r_busy[w_free_idx]  <= 1'b1;
                r_inst[w_free_idx]  <= dispatch_inst;
                r_pc[w_free_idx]    <= dispatch_pc;
                r_imm[w_free_idx]   <= dispatch_imm;
                r_tag[w_free_idx]   <= dispatch_tag;
                r_rely1[w_free_idx] <= w_new_rely1;
                r_rely2[w_free_idx] <= w_new_rely2;
                r_val1[w_free_idx]  <= w_new_val1;
                r_val2[w_free_idx]  <= w_new_val2;
                r_age[w_free_idx]   <= '0;
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (IDX_W'(i) != w_free_idx) r_age[i][w_free_idx] <= r_busy[i];
                end
            end else if (dispatch_valid) begin
                r_err <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (int'(w_count_nxt) >= RS_DEPTH - FULL_SLACK);
        end
    end

    assign out_valid      = r_out_valid;
    assign out_inst       = r_out_inst;
    assign out_pc         = r_out_pc;
    assign out_imm        = r_out_imm;
    assign out_rs1_val    = r_out_v1;
    assign out_rs2_val    = r_out_v2;
    assign out_tag        = r_out_tag;
    assign full_o         = r_full;
    assign count_o        = r_count;
    assign err_overflow_o = r_err;

endmodule
`default_nettype wire
